// File: rtl/branch_resolve_id.sv
// rtl/branch_resolve_id.sv - decode-stage branch resolver driving predictor update and fetch redirect
module branch_resolve_id #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             Valid_IN_ID,
  input  logic [31:0]      Instr_IN_ID,
  input  logic [31:0]      Instr_PC_IN_ID,
  input  logic             Pred_Taken_IN_ID,
  input  logic [31:0]      Pred_Target_IN_ID,
  input  logic [31:0]      RS_Data_IN_ID,
  input  logic [31:0]      RT_Data_IN_ID,
  input  logic             Ops_Ready_IN_ID,
  output logic             is_Branch_OUT,
  output logic             is_Taken_OUT,
  output logic [31:0]      Alt_PC_OUT,
  output logic [31:0]      Instr_PC_OUT,
  output logic             Redirect_OUT,
  output logic [31:0]      Redirect_PC_OUT,
  output logic             Hazard_Stall_OUT,
  output logic             Squash_OUT,
  output logic [CNT_W-1:0] Branch_Count_OUT,
  output logic [CNT_W-1:0] Mispred_Count_OUT
);

  typedef enum logic [1:0] {RUN, WAIT_OPS, SQUASH} state_t;

  state_t             state_q, state_d;
  logic               slot_seen_q, slot_seen_d;
  logic               is_branch_q, is_branch_d;
  logic               is_taken_q, is_taken_d;
  logic [31:0]        alt_pc_q, alt_pc_d;
  logic [31:0]        instr_pc_q, instr_pc_d;
  logic               redirect_q, redirect_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [5:0]         opcode, funct;
  logic [4:0]         rt_field;
  logic               is_cond, is_jump, is_jreg, is_br, needs_ops;
  logic               cond_taken, actual_taken, mispred;
  logic [31:0]        pc4, pc8, target;
  logic signed [31:0] rs_s;
  logic               resolve, hazard, squash;

  always_comb begin
    opcode   = Instr_IN_ID[31:26];
    funct    = Instr_IN_ID[5:0];
    rt_field = Instr_IN_ID[20:16];
    rs_s     = $signed(RS_Data_IN_ID);
    pc4      = Instr_PC_IN_ID + 32'd4;
    pc8      = Instr_PC_IN_ID + 32'd8;
    is_jump  = (opcode == 6'h02) || (opcode == 6'h03);
    is_jreg  = (opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09));
    is_cond  = 1'b0;
    cond_taken = 1'b0;
    case (opcode)
      6'h04: begin is_cond = 1'b1; cond_taken = (RS_Data_IN_ID == RT_Data_IN_ID); end
      6'h05: begin is_cond = 1'b1; cond_taken = (RS_Data_IN_ID != RT_Data_IN_ID); end
      6'h06: begin is_cond = 1'b1; cond_taken = (rs_s <= 0); end
      6'h07: begin is_cond = 1'b1; cond_taken = (rs_s > 0); end
      6'h01: begin
        if (rt_field == 5'h00) begin is_cond = 1'b1; cond_taken = (rs_s < 0); end
        if (rt_field == 5'h01) begin is_cond = 1'b1; cond_taken = (rs_s >= 0); end
      end
      default: ;
    endcase
    if (is_jump)      target = {pc4[31:28], Instr_IN_ID[25:0], 2'b00};
    else if (is_jreg) target = RS_Data_IN_ID;
    else              target = pc4 + {{14{Instr_IN_ID[15]}}, Instr_IN_ID[15:0], 2'b00};
    is_br        = is_cond || is_jump || is_jreg;
    needs_ops    = is_cond || is_jreg;
    actual_taken = is_jump || is_jreg || cond_taken;
    mispred      = (actual_taken != Pred_Taken_IN_ID) ||
                   (actual_taken && (target != Pred_Target_IN_ID));
  end

  always_comb begin
    state_d     = state_q;
    slot_seen_d = slot_seen_q;
    resolve     = 1'b0;
    hazard      = 1'b0;
    squash      = 1'b0;
    case (state_q)
      RUN: begin
        if (Valid_IN_ID && is_br) begin
          if (needs_ops && !Ops_Ready_IN_ID) begin
            hazard  = 1'b1;
            state_d = WAIT_OPS;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      WAIT_OPS: begin
        if (!Ops_Ready_IN_ID)         hazard  = 1'b1;
        else if (Valid_IN_ID && is_br) resolve = 1'b1;
        else                           state_d = RUN;
      end
      SQUASH: begin
        // The delay slot runs as ordinary work; only the instruction after it is on the wrong path.
        if (Valid_IN_ID) begin
          if (!slot_seen_q) begin
            slot_seen_d = 1'b1;
          end else begin
            squash      = 1'b1;
            slot_seen_d = 1'b0;
            state_d     = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (resolve) begin
      state_d     = mispred ? SQUASH : RUN;
      slot_seen_d = 1'b0;
    end

    is_branch_d   = resolve;
    is_taken_d    = resolve && actual_taken;
    redirect_d    = resolve && mispred;
    alt_pc_d      = resolve ? target : alt_pc_q;
    instr_pc_d    = resolve ? Instr_PC_IN_ID : instr_pc_q;
    redirect_pc_d = resolve ? (actual_taken ? target : pc8) : redirect_pc_q;
    branch_cnt_d  = (resolve && (branch_cnt_q != '1)) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
    mispred_cnt_d = (resolve && mispred && (mispred_cnt_q != '1)) ?
                    mispred_cnt_q + CNT_W'(1) : mispred_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RUN;
      slot_seen_q   <= 1'b0;
      is_branch_q   <= 1'b0;
      is_taken_q    <= 1'b0;
      alt_pc_q      <= '0;
      instr_pc_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (!STALL) begin
      state_q       <= state_d;
      slot_seen_q   <= slot_seen_d;
      is_branch_q   <= is_branch_d;
      is_taken_q    <= is_taken_d;
      alt_pc_q      <= alt_pc_d;
      instr_pc_q    <= instr_pc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign is_Branch_OUT     = is_branch_q;
  assign is_Taken_OUT      = is_taken_q;
  assign Alt_PC_OUT        = alt_pc_q;
  assign Instr_PC_OUT      = instr_pc_q;
  assign Redirect_OUT      = redirect_q;
  assign Redirect_PC_OUT   = redirect_pc_q;
  assign Branch_Count_OUT  = branch_cnt_q;
  assign Mispred_Count_OUT = mispred_cnt_q;
  assign Hazard_Stall_OUT  = hazard;
  assign Squash_OUT        = squash;

endmodule

// File: tb/tb_branch_resolve_id.sv
// tb/tb_branch_resolve_id.sv - scoreboard bench for branch_resolve_id
module tb_branch_resolve_id;

  logic        clk = 1'b0;
  logic        rst, stall, valid, pred_taken, ops_ready;
  logic [31:0] instr, pc, pred_target, rs_data, rt_data;
  logic        is_branch, is_taken, redirect, hazard, squash;
  logic [31:0] alt_pc, instr_pc, redirect_pc;
  logic [15:0] bcnt, mcnt;

  always #5 clk = ~clk;

  branch_resolve_id #(.CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .STALL(stall), .Valid_IN_ID(valid),
    .Instr_IN_ID(instr), .Instr_PC_IN_ID(pc), .Pred_Taken_IN_ID(pred_taken),
    .Pred_Target_IN_ID(pred_target), .RS_Data_IN_ID(rs_data), .RT_Data_IN_ID(rt_data),
    .Ops_Ready_IN_ID(ops_ready), .is_Branch_OUT(is_branch), .is_Taken_OUT(is_taken),
    .Alt_PC_OUT(alt_pc), .Instr_PC_OUT(instr_pc), .Redirect_OUT(redirect),
    .Redirect_PC_OUT(redirect_pc), .Hazard_Stall_OUT(hazard), .Squash_OUT(squash),
    .Branch_Count_OUT(bcnt), .Mispred_Count_OUT(mcnt)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] alt;
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_bc = '0;
  logic [15:0] exp_mc = '0;
  bit          sb_en = 1'b1;

  localparam logic [31:0] NOP = 32'h0000_0020;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic pt, input logic [31:0] ptg, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ops);
    valid = v; instr = ins; pc = p; pred_taken = pt; pred_target = ptg;
    rs_data = rs; rt_data = rt; ops_ready = ops;
    #1;
  endtask

  task automatic expect_res(input logic taken, input logic [31:0] alt, input logic [31:0] p,
                            input logic redir, input logic [31:0] rpc);
    exp_t e;
    if (exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    if (redir && exp_mc != 16'hFFFF) exp_mc = exp_mc + 16'd1;
    e.taken = taken; e.alt = alt; e.pc = p; e.redir = redir; e.rpc = rpc;
    e.bc = exp_bc; e.mc = exp_mc;
    sb_q.push_back(e);
  endtask

  // Outputs move only on an edge that saw neither STALL nor RESET; those edges pop the scoreboard.
  task automatic tick();
    logic held;
    exp_t e;
    held = stall | rst;
    @(posedge clk);
    #1;
    if (sb_en && !held) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("is_branch", {31'b0, is_branch}, 32'd1);
        check("is_taken", {31'b0, is_taken}, {31'b0, e.taken});
        check("alt_pc", alt_pc, e.alt);
        check("instr_pc", instr_pc, e.pc);
        check("redirect", {31'b0, redirect}, {31'b0, e.redir});
        if (e.redir) check("redirect_pc", redirect_pc, e.rpc);
        check("branch_cnt", {16'b0, bcnt}, {16'b0, e.bc});
        check("mispred_cnt", {16'b0, mcnt}, {16'b0, e.mc});
      end else begin
        check("no_pulse", {30'b0, is_branch, redirect}, 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(1'b0, NOP, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_is_branch", {31'b0, is_branch}, 32'd0);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_alt_pc", alt_pc, 32'd0);
    check("rst_bcnt", {16'b0, bcnt}, 32'd0);
    check("rst_mcnt", {16'b0, mcnt}, 32'd0);
    check("rst_hazard", {31'b0, hazard}, 32'd0);

    // BEQ taken, predicted not-taken
    drive(1'b1, itype(6'h04, 5'd2, 16'h0004), 32'h100, 1'b0, 32'h0, 32'd5, 32'd5, 1'b1);
    check("beq_hazard", {31'b0, hazard}, 32'd0);
    expect_res(1'b1, 32'h114, 32'h100, 1'b1, 32'h114);
    tick();
    drive(1'b1, NOP, 32'h104, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("beq_slot_squash", {31'b0, squash}, 32'd0);
    tick();
    drive(1'b1, NOP, 32'h108, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("beq_wrong_squash", {31'b0, squash}, 32'd1);
    tick();

    // BNE not taken, predicted taken; branches in delay slot / wrong path are not resolved
    drive(1'b1, itype(6'h05, 5'd2, 16'h0010), 32'h200, 1'b1, 32'h300, 32'd9, 32'd9, 1'b1);
    expect_res(1'b0, 32'h244, 32'h200, 1'b1, 32'h208);
    tick();
    drive(1'b1, itype(6'h04, 5'd2, 16'h0004), 32'h204, 1'b0, 32'h0, 32'd1, 32'd1, 1'b1);
    check("bne_slot_squash", {31'b0, squash}, 32'd0);
    tick();
    drive(1'b1, {6'h02, 26'h100}, 32'h208, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("bne_wrong_squash", {31'b0, squash}, 32'd1);
    tick();
    drive(1'b0, itype(6'h04, 5'd2, 16'h0004), 32'h300, 1'b0, 32'h0, 32'd1, 32'd1, 1'b1);
    check("invalid_squash", {31'b0, squash}, 32'd0);
    tick();
    drive(1'b1, NOP, 32'h304, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();

    // BGTZ waits three cycles for operands
    drive(1'b1, itype(6'h07, 5'd0, 16'hFFFF), 32'h300, 1'b1, 32'h300, 32'd7, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bgtz_hazard", {31'b0, hazard}, 32'd1);
      tick();
    end
    drive(1'b1, itype(6'h07, 5'd0, 16'hFFFF), 32'h300, 1'b1, 32'h300, 32'd7, 32'd0, 1'b1);
    check("bgtz_ready_hazard", {31'b0, hazard}, 32'd0);
    expect_res(1'b1, 32'h300, 32'h300, 1'b0, 32'h0);
    tick();

    // JR correct, then JALR back-to-back with wrong target
    drive(1'b1, {6'h00, 5'd2, 15'd0, 6'h08}, 32'h400, 1'b1, 32'h4000, 32'h4000, 32'h0, 1'b1);
    expect_res(1'b1, 32'h4000, 32'h400, 1'b0, 32'h0);
    tick();
    drive(1'b1, {6'h00, 5'd2, 15'd0, 6'h09}, 32'h404, 1'b1, 32'h4004, 32'h4000, 32'h0, 1'b1);
    expect_res(1'b1, 32'h4000, 32'h404, 1'b1, 32'h4000);
    tick();
    drive(1'b1, NOP, 32'h408, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, NOP, 32'h40C, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("jalr_wrong_squash", {31'b0, squash}, 32'd1);
    tick();

    // REGIMM and BLEZ with wrapping negative offset
    drive(1'b1, itype(6'h01, 5'h00, 16'h0002), 32'h500, 1'b1, 32'h50C, 32'hFFFF_FFFF, 32'h0, 1'b1);
    expect_res(1'b1, 32'h50C, 32'h500, 1'b0, 32'h0);
    tick();
    drive(1'b1, itype(6'h01, 5'h01, 16'h0002), 32'h504, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    expect_res(1'b0, 32'h510, 32'h504, 1'b0, 32'h0);
    tick();
    drive(1'b1, itype(6'h06, 5'h00, 16'h8000), 32'h508, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    expect_res(1'b1, 32'hFFFE_050C, 32'h508, 1'b1, 32'hFFFE_050C);
    tick();
    drive(1'b1, NOP, 32'h50C, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b1, NOP, 32'h510, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("blez_wrong_squash", {31'b0, squash}, 32'd1);
    tick();

    // JAL never waits on operands; then hold its pulse under STALL
    drive(1'b1, {6'h03, 26'h40}, 32'hF000_0000, 1'b1, 32'hF000_0100, 32'h0, 32'h0, 1'b0);
    check("jal_hazard", {31'b0, hazard}, 32'd0);
    expect_res(1'b1, 32'hF000_0100, 32'hF000_0000, 1'b0, 32'h0);
    tick();
    stall = 1'b1;
    drive(1'b1, itype(6'h04, 5'd2, 16'h0004), 32'h600, 1'b0, 32'h0, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_hold_branch", {31'b0, is_branch}, 32'd1);
      check("stall_hold_bcnt", {16'b0, bcnt}, {16'b0, exp_bc});
    end
    stall = 1'b0;
    drive(1'b1, NOP, 32'h600, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();

    // Reset with stall asserted while in WAIT_OPS
    drive(1'b1, itype(6'h07, 5'd0, 16'h0001), 32'h700, 1'b0, 32'h0, 32'd3, 32'd0, 1'b0);
    tick();
    drive(1'b0, NOP, 32'h704, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("wait_hazard", {31'b0, hazard}, 32'd1);
    rst = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    #1;
    exp_bc = '0; exp_mc = '0;
    check("rst2_hazard", {31'b0, hazard}, 32'd0);
    check("rst2_bcnt", {16'b0, bcnt}, 32'd0);
    check("rst2_mcnt", {16'b0, mcnt}, 32'd0);
    check("rst2_branch", {30'b0, is_branch, redirect}, 32'd0);
    check("rst2_redirect_pc", redirect_pc, 32'd0);

    // Saturation: J at PC 0 resolves correctly every cycle
    sb_en = 1'b0;
    drive(1'b1, {6'h02, 26'h0}, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (65535) tick();
    check("sat_reach", {16'b0, bcnt}, 32'h0000_FFFF);
    repeat (2) tick();
    check("sat_hold", {16'b0, bcnt}, 32'h0000_FFFF);
    check("sat_mcnt", {16'b0, mcnt}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_id.md
# branch_resolve_id

Decode-stage branch resolver: the producer side of the predictor's ID-update interface. It decodes the instruction in ID, evaluates branch conditions on forwarded register operands and computes the actual target. It compares the outcome against the prediction carried down from IF, then drives the registered update/redirect pulses consumed by the BTB and the fetch PC mux. It also squashes the wrong-path fetch slot and keeps saturating branch/mispredict statistics.

## Interface
- CNT_W, 16: width of statistics counters.
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  global pipeline stall; freezes all state and outputs.
- Valid_IN_ID  in  1  ID holds a real instruction.
- Instr_IN_ID  in  32  instruction word in ID.
- Instr_PC_IN_ID  in  32  PC of instruction in ID.
- Pred_Taken_IN_ID  in  1  IF prediction (taken) for this instruction.
- Pred_Target_IN_ID  in  32  IF predicted target (valid when Pred_Taken_IN_ID).
- RS_Data_IN_ID, RT_Data_IN_ID  in  32 each  forwarded operands.
- Ops_Ready_IN_ID  in  1  forwarding has final values for rs/rt.
- is_Branch_OUT  out  1  update pulse: a control-transfer instruction resolved.
- is_Taken_OUT  out  1  actual direction of that instruction.
- Alt_PC_OUT  out  32  actual taken target.
- Instr_PC_OUT  out  32  PC of resolved instruction.
- Redirect_OUT  out  1  mispredict pulse to fetch.
- Redirect_PC_OUT  out  32  correct fetch PC.
- Hazard_Stall_OUT  out  1  combinational; request upstream stall (operands not ready).
- Squash_OUT  out  1  combinational; kill instruction currently in ID.
- Branch_Count_OUT, Mispred_Count_OUT  out  CNT_W  saturating statistics.

## Operation
- Decode (opcode [31:26], funct [5:0], rt [20:16]): BEQ 04, BNE 05, BLEZ 06, BGTZ 07, REGIMM 01 with rt 00 BLTZ / 01 BGEZ → conditional. J 02, JAL 03 → always taken. SPECIAL 00 with funct 08 JR / 09 JALR → always taken, register target. Everything else is a non-branch.
- Targets: conditional = PC+4 + {sext(imm[15:0]),2'b00} (32-bit wrap). J/JAL = {(PC+4)[31:28], instr[25:0], 2'b00}. JR/JALR = RS_Data.
- Conditions: signed compares on RS (BLEZ: rs<=0, BGTZ: rs>0, BLTZ: rs<0, BGEZ: rs>=0); BEQ/BNE compare RS with RT.
- Mispredict = actual_taken != Pred_Taken, or both taken and target != Pred_Target. Redirect_PC = taken ? target : PC+8 (delay slot always executes).
- FSM RUN / WAIT_OPS / SQUASH:
  - RUN, valid branch, Ops_Ready=0 (or JR/JALR/cond): → WAIT_OPS, Hazard_Stall_OUT=1, nothing resolved. J/JAL never wait.
  - WAIT_OPS: Hazard_Stall_OUT=1 until Ops_Ready=1, then resolves that cycle as in RUN.
  - Resolve: register is_Branch_OUT=1, is_Taken_OUT, Alt_PC_OUT, Instr_PC_OUT. On mispredict also Redirect_OUT=1, Redirect_PC_OUT, Mispred_Count+1, → SQUASH; else → RUN.
  - SQUASH: first valid ID instruction is the delay slot — processed, but never resolved as a branch (illegal in delay slot; treated as non-branch). The next valid ID instruction (wrong path) gets Squash_OUT=1, is not resolved, then → RUN.
- Branch_Count +1 per resolved branch. Counters saturate at all-ones, never wrap.
- Non-branch or Valid_IN_ID=0: no pulses.

## Timing
- Resolution in cycle t → outputs visible t+1, held exactly one non-stalled cycle (pulses return to 0 at t+2 unless another resolve).
- STALL=1: no register/FSM/counter changes; pulses held; Hazard_Stall_OUT/Squash_OUT still evaluated from current state.
- Reset (any cycle, incl. WAIT_OPS/SQUASH): state RUN, all outputs 0, counters 0, pulses cleared next edge; RESET has priority over STALL.
- Back-to-back resolves in consecutive cycles allowed (outside SQUASH delay-slot rule).
- Redirect and update come from the same registered cycle.

## Test plan
- BEQ at PC 0x100, imm 0x0004, RS=RT=5, Pred_Taken=0 → next cycle is_Branch=1, is_Taken=1, Alt_PC=0x114, Redirect=1, Redirect_PC=0x114, Mispred_Count=1.
- BNE at 0x200, RS=RT, Pred_Taken=1 target 0x300 → is_Taken=0, Redirect_PC=0x208; delay-slot instr passes, following instr has Squash_OUT=1.
- BGTZ, Ops_Ready low 3 cycles → Hazard_Stall_OUT=1 for 3 cycles, no pulse; resolves the cycle Ops_Ready rises.
- JR with RS=0x4000, Pred_Taken=1 target 0x4000 → is_Branch=1, is_Taken=1, no Redirect; same with target 0x4004 → Redirect to 0x4000.
- STALL high 2 cycles while is_Branch=1 → pulse held 2 extra cycles, counters unchanged; RESET during WAIT_OPS → all outputs 0, state RUN.
- Force 2^CNT_W branches → Branch_Count_OUT saturates at 0xFFFF.
